// File: rtl/call_stack_pkg.sv
// Shared processor constants: instruction width and the return-stack defaults,
// plus the stack operation encoding used by the call-stack control logic.
package call_stack_pkg;

    localparam int INSTR_W     = 19;
    localparam int CS_DEPTH    = 8;
    localparam int CS_ADDR_W   = 12;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_SWAP = 2'b11
    } stack_op_e;

endpackage

// File: rtl/stack_regfile.sv
// Return-address storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; the top-level masks any entry that is not valid.
module stack_regfile #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 12
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [ADDR_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [ADDR_W-1:0]        rd_data
);

    logic [ADDR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/call_stack.sv
// Hardware return-address stack for JSB/RET: count pointer, sticky error flags
// and push/pop/flush priority; entries live in stack_regfile.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int DEPTH  = CS_DEPTH,
    parameter int ADDR_W = CS_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [ADDR_W-1:0]      push_data,
    output logic [ADDR_W-1:0]      top,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [CNT_W-1:0]  count_nxt;
    logic              ovf_set;
    logic              unf_set;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  top_idx;
    logic [ADDR_W-1:0] rd_data;
    stack_op_e         op;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign top_idx = IDX_W'(count - CNT_W'(1));
    assign top     = empty ? '0 : rd_data;
    assign op      = stack_op_e'({push, pop});

    always_comb begin
        count_nxt = count;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = IDX_W'(count);
        if (flush) begin
            count_nxt = '0;
        end else begin
            case (op)
                OP_PUSH: begin
                    if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        wr_en     = 1'b1;
                        count_nxt = count + CNT_W'(1);
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        unf_set = 1'b1;
                    end else begin
                        count_nxt = count - CNT_W'(1);
                    end
                end
                OP_SWAP: begin
                    // Empty swap degenerates into a plain push into slot 0.
                    wr_en = 1'b1;
                    if (empty) begin
                        unf_set   = 1'b1;
                        count_nxt = CNT_W'(1);
                    end else begin
                        wr_idx = top_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_nxt;
            overflow  <= overflow | ovf_set;
            underflow <= underflow | unf_set;
        end
    end

    stack_regfile #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .wr_en   (wr_en & ~reset),
        .wr_idx  (wr_idx),
        .wr_data (push_data),
        .rd_idx  (top_idx),
        .rd_data (rd_data)
    );

endmodule

// File: doc/call_stack.md
CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the number of return-address entries (power of two, at least 2).
REQ-002 Parameter ADDR_W, default 12, SHALL set the return-address width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 push  input  1  SHALL request a push, driven by the controller on JSB.
REQ-006 pop  input  1  SHALL request a pop, driven by the controller on RET.
REQ-007 flush  input  1  SHALL request that all entries be discarded; sticky flags are kept.
REQ-008 push_data  input  ADDR_W  SHALL carry the return address to store, i.e. PC+1 of the JSB.
REQ-009 top  output  ADDR_W  SHALL carry the most recently pushed valid entry, used as the RET target (pc_mux=11).
REQ-010 count  output  $clog2(DEPTH)+1  SHALL carry the number of valid entries.
REQ-011 empty, full  output  1 each  SHALL indicate count==0 and count==DEPTH respectively.
REQ-012 overflow, underflow  output  1 each  SHALL be sticky error flags.

Function
REQ-013 top, empty and full SHALL be combinational from the current state (zero latency), so a RET can redirect the PC in the same cycle pop is asserted.
REQ-014 top SHALL equal entry[count-1] when not empty, and 0 when empty.
REQ-015 Push only, not full: the block SHALL write entry[count] <= push_data and increment count at the edge.
REQ-016 Push only, full: the block SHALL leave entries and count unchanged and set overflow.
REQ-017 Pop only, not empty: the block SHALL decrement count at the edge; entry contents need not be cleared.
REQ-018 Pop only, empty: the block SHALL leave count at 0 and set underflow.
REQ-019 Push and pop together, not empty: the block SHALL replace the top entry with push_data and leave count unchanged; no flag is set, even when full.
REQ-020 Push and pop together, empty: the block SHALL act as a push only and set underflow.
REQ-021 flush SHALL have priority over push and pop: count becomes 0 at the edge, and push/pop in that cycle are ignored with no flags set.
REQ-022 Once set, overflow and underflow SHALL remain set until reset.
REQ-023 count SHALL never exceed DEPTH and never wrap below 0.

Reset
REQ-024 When reset is high at a rising edge: count=0, empty=1, full=0, overflow=0, underflow=0, top=0.
REQ-025 reset SHALL have priority over flush, push and pop; a push or pop in the reset cycle is discarded.
REQ-026 Entry storage SHALL NOT require a reset; no uninitialised entry may ever reach top (guaranteed by REQ-014).

Structure
REQ-027 DEPTH and ADDR_W defaults SHALL live in the shared processor constants package alongside the 19-bit instruction-width constant.
REQ-028 One sub-module, stack_regfile, SHALL hold the entry array: one synchronous write port and one asynchronous read port.
REQ-029 Pointer, flag and priority logic SHALL remain in call_stack.

Verification
REQ-030 Reset, then push 0x010, 0x020, 0x030 in consecutive cycles -> count=3, top=0x030; then pop -> top=0x020 in the same cycle the next pop is sampled.
REQ-031 Push 8 distinct values 0x100..0x107, then push 0x1FF -> full=1, overflow=1, count=8, top=0x107.
REQ-032 From reset, pop -> underflow=1, count=0, top=0, empty=1; a following push 0x055 -> top=0x055 with underflow still 1.
REQ-033 With stack [0x011, 0x022], assert push and pop with push_data=0x0AA -> count=2, top=0x0AA; then pop -> top=0x011.
REQ-034 With count=5, assert flush and push together -> count=0, empty=1, no flag change; with count=3, assert reset and push together -> all reset values per REQ-024.
REQ-035 Random push/pop/flush sequence of at least 2000 cycles checked against a reference model for top, count, empty, full and both flags every cycle.
